// File: rtl/addsub_result_buffer.sv
// addsub_result_buffer: derives status flags for add/sub slice results and
// buffers them in a first-word-fall-through FIFO with a sticky overflow flag.
module addsub_result_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_res,
   input  logic             in_cout,
   input  logic             in_sub,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_res,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf,
   output logic             out_sub,
   output logic [PTR_W:0]   count,
   output logic             ovf_sticky
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   logic [8:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [8:0]       head;
   logic             ovf, push, pop;
   // b_msb arrives uninverted, so subtract overflow needs differing operand signs
   assign ovf = (in_sub ? (in_a_msb != in_b_msb) : (in_a_msb == in_b_msb)) && (in_res[3] != in_a_msb);
   assign in_ready = count != FULL;
   assign out_valid = count != '0;
   assign push = in_valid && in_ready;
   assign pop = out_valid && out_ready;
   assign head = out_valid ? mem[rd_ptr] : '0;
   assign {out_sub, out_ovf, out_neg, out_zero, out_carry, out_res} = head;
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_sub, ovf, in_res[3], in_res == 4'd0, in_cout, in_res};
   end
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         if (push && ovf) ovf_sticky <= 1'b1;
      end
   end
endmodule

// File: tb/tb_addsub_result_buffer.sv
// tb_addsub_result_buffer: directed vectors with a queue scoreboard and pop monitor.
module tb_addsub_result_buffer;
   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, in_ready, in_cout, in_sub, in_a_msb, in_b_msb;
   logic [3:0] in_res, out_res;
   logic       out_valid, out_ready, out_carry, out_zero, out_neg, out_ovf, out_sub, ovf_sticky;
   logic [2:0] count;
   int         total = 0;
   int         bad = 0;
   logic [8:0] cur_exp;
   logic [8:0] q[$];
   typedef struct {
      logic [3:0] res;
      logic       cout, sub, a, b;
      logic [8:0] exp;
   } vec_t;
   vec_t v[8];

   addsub_result_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_res(in_res), .in_cout(in_cout), .in_sub(in_sub), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_carry(out_carry),
      .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf), .out_sub(out_sub),
      .count(count), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [8:0] act, logic [8:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   // expected entries enter the scoreboard on the accepting handshake
   always @(negedge clk) begin
      if (!rst_n || flush) q.delete();
      else if (in_valid && in_ready) q.push_back(cur_exp);
   end

   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected got=%h at %0t",
                     {out_sub, out_ovf, out_neg, out_zero, out_carry, out_res}, $time);
         end else check("pop", {out_sub, out_ovf, out_neg, out_zero, out_carry, out_res}, q.pop_front());
      end
   end

   task automatic set_in(int i);
      in_res = v[i].res; in_cout = v[i].cout; in_sub = v[i].sub;
      in_a_msb = v[i].a; in_b_msb = v[i].b; cur_exp = v[i].exp;
   endtask

   task automatic send(int i);
      int n;
      set_in(i);
      in_valid = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (n == 50) begin
         total++;
         bad++;
         $display("FAIL send_timeout got=0 want=1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (count == 0) break;
      end
      check("drain_count", 9'(count), 9'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic check_cleared(string name);
      @(negedge clk);
      check({name, "_count"}, 9'(count), 9'd0);
      check({name, "_valid"}, 9'(out_valid), 9'd0);
      check({name, "_ready"}, 9'(in_ready), 9'd1);
      check({name, "_sticky"}, 9'(ovf_sticky), 9'd0);
      check({name, "_outs"}, {out_sub, out_ovf, out_neg, out_zero, out_carry, out_res}, 9'd0);
   endtask

   initial begin
      v[0] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0B0};
      v[1] = '{4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 9'h102};
      v[2] = '{4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 9'h15E};
      v[3] = '{4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 9'h007};
      v[4] = '{4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0C9};
      v[5] = '{4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 9'h187};
      v[6] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0C8};
      v[7] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h030};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_in(3);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_cleared("reset");
      @(posedge clk); #1;

      send(0);
      @(negedge clk);
      check("ovf_push_count", 9'(count), 9'd1);
      check("ovf_push_sticky", 9'(ovf_sticky), 9'd1);
      check("ovf_push_head", {out_sub, out_ovf, out_neg, out_zero, out_carry, out_res}, v[0].exp);
      @(negedge clk);
      check("hold_head", {out_sub, out_ovf, out_neg, out_zero, out_carry, out_res}, v[0].exp);
      @(posedge clk); #1;
      drain();

      send(1);
      send(2);
      drain();
      check("sticky_kept", 9'(ovf_sticky), 9'd1);

      for (int i = 3; i < 7; i++) send(i);
      @(negedge clk);
      check("full_count", 9'(count), 9'd4);
      check("full_ready", 9'(in_ready), 9'd0);
      @(posedge clk); #1;
      set_in(7);
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("full_hold_count", 9'(count), 9'd4);
      check("full_hold_ready", 9'(in_ready), 9'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("after_pop_count", 9'(count), 9'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("refill_count", 9'(count), 9'd4);
      @(posedge clk); #1;
      drain();

      send(0);
      send(1);
      for (int i = 2; i < 8; i++) begin
         set_in(i);
         in_valid = 1'b1;
         out_ready = 1'b1;
         @(negedge clk);
         check("stream_count", 9'(count), 9'd2);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      drain();

      send(3);
      send(0);
      send(6);
      @(negedge clk);
      check("pre_flush_count", 9'(count), 9'd3);
      check("pre_flush_sticky", 9'(ovf_sticky), 9'd1);
      @(posedge clk); #1;
      set_in(4);
      in_valid = 1'b1;
      out_ready = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      check_cleared("flush");
      @(posedge clk); #1;

      send(5);
      send(2);
      set_in(4);
      in_valid = 1'b1;
      out_ready = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      check_cleared("midreset");
      check("queue_empty", 9'(q.size()), 9'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/addsub_result_buffer.md
Name: addsub_result_buffer

Overview:
- Capture stage directly downstream of the team's 4-bit lookahead add/subtract slice (mode bit doubles as carry-in; cout is returned as borrow in subtract mode).
- Registers each result nibble and derives status flags: carry/borrow, zero, negative, signed overflow.
- Buffers results in a small first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Keeps a sticky overflow indicator for the control sequencer.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- flush  input  1  synchronous clear of FIFO contents and sticky flag.
- in_valid  input  1  upstream result is valid this cycle.
- in_ready  output  1  buffer can accept an entry.
- in_res  input  4  result nibble from the add/sub slice.
- in_cout  input  1  slice carry-out; this is the borrow when in_sub=1.
- in_sub  input  1  mode bit driven to the slice (1 = a-b).
- in_a_msb  input  1  bit 3 of operand a.
- in_b_msb  input  1  bit 3 of operand b, not inverted.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts the head entry.
- out_res  output  4  head result.
- out_carry  output  1  head carry (add) or borrow (sub).
- out_zero  output  1  head result is 0000.
- out_neg  output  1  head result bit 3.
- out_ovf  output  1  head signed overflow.
- out_sub  output  1  head mode bit.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- ovf_sticky  output  1  set when any overflow entry is pushed.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset, sampled at a clk edge with rst_n=0:
  - count=0, pointers=0, ovf_sticky=0, out_valid=0.
  - All out_* data outputs = 0; in_ready=1 from the first cycle after reset.
  - Reset overrides flush, push and pop.
  - Reset mid-operation discards all entries; no partial pop is visible.
- Flag computation, at push time, from the inputs:
  - zero = (in_res==0).
  - neg = in_res[3].
  - carry = in_cout.
  - ovf add (in_sub=0): (a_msb==b_msb) && (in_res[3]!=a_msb).
  - ovf sub (in_sub=1): (a_msb!=b_msb) && (in_res[3]!=a_msb).
- Storage: each entry is 9 bits {sub, ovf, neg, zero, carry, res[3:0]}.
- Push occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH), combinational from registered count.
  - No write-through when full: in_ready stays 0 even if out_ready=1.
- Pop occurs when out_valid && out_ready.
  - out_valid = (count != 0).
  - out_* are driven combinationally from the head entry, and forced to 0 when empty.
- Latency: an entry pushed at edge N appears on out_* with out_valid=1 after edge N (one cycle), including when the FIFO was empty.
- Simultaneous push and pop with 0<count<DEPTH: both complete and count is unchanged.
  - Push into empty with out_ready=1: no pop that cycle, because out_valid=0.
- Pointers wrap modulo DEPTH. Order is strict FIFO.
- in_valid while in_ready=0: ignored. Upstream must hold the result; nothing is lost or duplicated.
- out_* hold stable while out_valid=1 && out_ready=0.
- ovf_sticky:
  - Set on the edge of any push whose ovf=1.
  - Cleared only by reset or flush.
  - A push with ovf=1 in the same cycle as flush leaves ovf_sticky=0 and is discarded.
- flush=1 at an edge: count=0, pointers=0, ovf_sticky=0, in-flight push and pop ignored.

Test Plan:
- Reset hold 2 cycles, then release → count=0, out_valid=0, in_ready=1, ovf_sticky=0, out_res=0.
- Push add res=0000, cout=1, a_msb=1, b_msb=1 (8+8) → next cycle out_res=0, carry=1, zero=1, neg=0, ovf=1; ovf_sticky=1.
- Push sub 5-3: res=0010, cout=0, a_msb=0, b_msb=0 → carry=0, ovf=0, zero=0. Then push sub 3-5: res=1110, cout=1 → carry=1, neg=1, ovf=0.
- Push 5 entries with out_ready=0 → after 4, count=4 and in_ready=0. The 5th is held by upstream and accepted only after one pop. Pop order matches push order across pointer wrap.
- count=2 with in_valid=1 and out_ready=1 every cycle for 6 cycles → count stays 2; the output sequence equals the input sequence delayed by 2 entries.
- flush asserted with count=3, push active, and ovf_sticky=1 → next cycle count=0, out_valid=0, ovf_sticky=0. rst_n low mid-stream yields the same cleared state.
